freq_meter: RTL and testbench
=============================

# freq_meter

Measures the frequency of an external square-wave input (a note clock, button line or test pin) by counting its rising edges over a fixed gate window derived from the 100 MHz system clock. This is the measurement counterpart of the note-clock dividers. A new result, in edges per window, is presented once per window with a one-cycle valid strobe. It sits between board-level inputs and the display/debug logic.

## Interface
- CLK_HZ, 100000000, system clock frequency in Hz
- GATE_HZ, 1, gate windows per second; window length GATE_CYC = CLK_HZ/GATE_HZ cycles (integer, ≥ 4)
- CNT_W, 32, width of the edge counter and result
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset, asynchronous and active-high; all flops clear immediately
- en  input  1  measurement enable, synchronous to clk
- sig_in  input  1  signal under test, asynchronous to clk
- freq  output  CNT_W  rising edges counted in the last completed window
- overflow  output  1  last completed window saturated the counter
- valid  output  1  one-cycle strobe; freq/overflow updated this cycle

## Operation
- Input path: sig_in goes through a 2-flop synchronizer (s1, s2), then a previous-value flop s3. rise = s2 & ~s3. The sync chain runs in every state; all three flops reset to 0.
- FSM states:
  - IDLE: gate counter and edge counter held at 0; rise is ignored. IDLE → MEASURE when en = 1.
  - MEASURE: gate counter increments each cycle, 0 .. GATE_CYC-1. Edge counter increments on rise.
- Terminal cycle (gate = GATE_CYC-1, en = 1):
  - freq ← edge_cnt + rise, saturating.
  - overflow ← 1 if the sum exceeded 2^CNT_W − 1, else 0.
  - valid = 1 for one cycle.
  - Gate counter → 0; edge counter → 0. An edge on the terminal cycle belongs to the ending window only.
  - Remain in MEASURE; windows are back-to-back with no dead cycles.
- Saturation: the edge counter stops at all-ones and never wraps. A sticky internal sat bit is set on saturation and cleared at window start.
- en = 0 in MEASURE (any cycle, including the terminal cycle): go to IDLE next cycle and clear both counters. No valid is issued; freq/overflow keep their last values.
- rst asserted mid-window: freq = 0, overflow = 0, valid = 0, state IDLE, counters 0. The window in progress is discarded.
- Counting is accurate for sig_in high and low phases each ≥ 2 clk cycles (f_sig ≤ CLK_HZ/4). Behaviour above that rate is undefined.

## Timing
- Reset values: freq = 0, overflow = 0, valid = 0, state IDLE, s1/s2/s3 = 0.
- sig_in rising → rise asserted: 2–3 clk cycles (synchronizer uncertainty). The edge is counted in the window containing the rise cycle.
- en sampled high at cycle t:
  - MEASURE starts at t+1 with gate = 0.
  - First valid at cycle t+GATE_CYC.
  - Subsequent valids every GATE_CYC cycles exactly.
- valid and the new freq/overflow change on the same clock edge. freq/overflow are registered and stable between strobes.
- No combinational path from any input to any output.

## Structure
- Package freq_meter_pkg holds:
  - state enum {IDLE, MEASURE};
  - function gate_cyc(CLK_HZ, GATE_HZ);
  - width helper clog2 for the gate counter, width = clog2(GATE_CYC).
- Sub-module sync_edge: 2-flop synchronizer plus rise detector, ports clk, rst, d, q, rise. Reusable for button inputs.
- Top level: FSM, gate counter, saturating edge counter, output registers.

## Test plan
All scenarios use CLK_HZ = 1000, GATE_HZ = 1 (GATE_CYC = 1000), CNT_W = 32 unless stated.
- Steady measurement: sig_in period 10 clk (5 high / 5 low), en held 1 → every valid 1000 cycles apart; after the first window, freq = 100, overflow = 0.
- Saturation: CNT_W = 4, sig_in period 10 → freq = 15, overflow = 1. Then sig_in period 100 → next full window freq = 10, overflow = 0.
- Enable drop: en low at gate = 500 for 3 cycles, then high → no valid for the aborted window; next valid exactly 1000 cycles after en returns high; freq matches a full window.
- Terminal-edge boundary: place the synchronized rise exactly on gate = 999 → that edge is counted in the ending window (freq = N+1) and not in the next.
- Async reset mid-window: assert rst at gate = 300 with freq = 100 → freq, overflow, valid read 0 immediately; after release with en = 1, first valid arrives 1000 cycles after MEASURE entry.
- Idle input: sig_in constant 1 from reset → no rise detected once s3 = 1; every window reports freq = 0 (except at most 1 on the first window); valid still strobes every 1000 cycles.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and elaboration-time helpers for the frequency meter.
// Holds the FSM state encoding and the gate-window sizing functions.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic int gate_cyc(input int clk_hz, input int gate_hz);
        return clk_hz / gate_hz;
    endfunction

    // Bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer with a trailing history flop and rising-edge detect.
// Suitable for any slow asynchronous level such as a push button.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    // sh_q[0] = first sync stage, sh_q[1] = second stage, sh_q[2] = previous value
    logic [2:0] sh_q;
    logic [2:0] sh_d;

    always_comb begin
        sh_d = {sh_q[1:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q    = sh_q[1];
    assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over back-to-back gate windows
// and publishes a saturating count with a one-cycle valid strobe per window.
module freq_meter #(
    parameter int CLK_HZ  = 100000000,
    parameter int GATE_HZ = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             overflow,
    output logic             valid
);

    import freq_meter_pkg::*;

    localparam int GATE_CYC = gate_cyc(CLK_HZ, GATE_HZ);
    localparam int GATE_W   = clog2(GATE_CYC);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic rise;
    logic sync_level_unused;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .q    (sync_level_unused),
        .rise (rise)
    );

    state_t            state_q, state_d;
    logic [GATE_W-1:0] gate_q,  gate_d;
    logic [CNT_W-1:0]  edge_q,  edge_d;
    logic              sat_q,   sat_d;
    logic [CNT_W-1:0]  freq_q,  freq_d;
    logic              ovf_q,   ovf_d;
    logic              valid_q, valid_d;

    logic at_max;
    logic terminal;

    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        edge_d   = edge_q;
        sat_d    = sat_q;
        freq_d   = freq_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        at_max   = (edge_q == CNT_MAX);
        terminal = (gate_q == GATE_LAST);

        case (state_q)
            IDLE: begin
                gate_d = '0;
                edge_d = '0;
                sat_d  = 1'b0;
                if (en) begin
                    state_d = MEASURE;
                end
            end

            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else if (terminal) begin
                    // A rise on the terminal cycle closes out the ending window.
                    valid_d = 1'b1;
                    freq_d  = (rise && !at_max) ? edge_q + 1'b1 : edge_q;
                    ovf_d   = sat_q | (at_max & rise);
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + 1'b1;
                    if (rise) begin
                        if (at_max) begin
                            sat_d = 1'b1;
                        end else begin
                            edge_d = edge_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign freq     = freq_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 32-bit and a 4-bit instance share stimulus,
// a sampled-edge window model predicts each result and a monitor checks every cycle.
module tb_freq_meter;

    localparam int CLK_HZ   = 1000;
    localparam int GATE_HZ  = 1;
    localparam int GATE_CYC = CLK_HZ / GATE_HZ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic sig_in = 1'b0;

    logic [31:0] freq_a;
    logic        ovf_a, valid_a;
    logic [3:0]  freq_b;
    logic        ovf_b, valid_b;

    freq_meter #(.CLK_HZ(CLK_HZ), .GATE_HZ(GATE_HZ), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq(freq_a), .overflow(ovf_a), .valid(valid_a)
    );

    freq_meter #(.CLK_HZ(CLK_HZ), .GATE_HZ(GATE_HZ), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq(freq_b), .overflow(ovf_b), .valid(valid_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_no;
        longint      cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;

    int gen_hi = 5;
    int gen_lo = 5;
    bit gen_run = 1'b0;
    bit gen_level = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Square-wave / level generator; updates shortly after each rising edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!gen_run) begin
                sig_in = gen_level;
                ph = 0;
            end else begin
                if (ph >= gen_hi + gen_lo) ph = 0;
                sig_in = (ph < gen_hi);
                ph = ph + 1;
            end
        end
    end

    // Reference: sig_in as seen at each clock edge; an edge is one 0->1 step of that
    // sampled stream, visible two edges later. Windows are GATE_CYC edges long.
    initial begin
        bit     h1, h2, h3, r, in_win;
        int     pos;
        longint cnt;
        exp_t   it;
        h1 = 0; h2 = 0; h3 = 0; in_win = 0; pos = 0; cnt = 0;
        forever begin
            @(posedge clk);
            cyc++;
            r = h2 & ~h3;
            if (rst) begin
                in_win = 0;
                h1 = 0; h2 = 0; h3 = 0;
            end else begin
                if (!in_win) begin
                    if (en) begin
                        in_win = 1; pos = 0; cnt = 0;
                    end
                end else if (!en) begin
                    in_win = 0;
                end else begin
                    cnt = cnt + longint'(r);
                    pos++;
                    if (pos == GATE_CYC) begin
                        it.edge_no = cyc;
                        it.cnt = cnt;
                        q_a.push_back(it);
                        q_b.push_back(it);
                        pos = 0;
                        cnt = 0;
                    end
                end
                h3 = h2; h2 = h1; h1 = sig_in;
            end
        end
    end

    task automatic score(input string tag, input logic v, input logic [63:0] f, input logic o,
                         input bit ev, input longint cnt, input longint mx,
                         inout longint hf, inout bit ho);
        check({tag, " valid"}, {63'd0, v}, {63'd0, ev});
        if (ev) begin
            hf = (cnt > mx) ? mx : cnt;
            ho = (cnt > mx);
            $display("window %s @%0d: edges=%0d freq=%0d overflow=%0d", tag, cyc, cnt, f, o);
        end
        check({tag, " freq"}, f, hf);
        check({tag, " overflow"}, {63'd0, o}, {63'd0, ho});
    endtask

    // Monitor: every falling edge, compare strobe timing, result and held values.
    initial begin
        longint hf_a, hf_b;
        bit     ho_a, ho_b, ea, eb;
        exp_t   it_a, it_b;
        hf_a = 0; hf_b = 0; ho_a = 0; ho_b = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hf_a = 0; hf_b = 0; ho_a = 0; ho_b = 0;
            end
            ea = (q_a.size() > 0) && (q_a[0].edge_no == cyc);
            eb = (q_b.size() > 0) && (q_b[0].edge_no == cyc);
            it_a.cnt = 0;
            it_b.cnt = 0;
            if (ea) it_a = q_a.pop_front();
            if (eb) it_b = q_b.pop_front();
            score("w32", valid_a, {32'd0, freq_a}, ovf_a, ea, it_a.cnt, 64'hFFFF_FFFF, hf_a, ho_a);
            score("w4", valid_b, {60'd0, freq_b}, ovf_b, eb, it_b.cnt, 15, hf_b, ho_b);
        end
    end

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * GATE_CYC; i++) begin
            @(negedge clk);
            if (valid_a) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("wait_valid timeout", 0, 1);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Constant-high input from reset.
        gen_run = 0;
        gen_level = 1;
        repeat (3) @(negedge clk);
        check("reset freq", {32'd0, freq_a}, 0);
        check("reset overflow", {63'd0, ovf_a}, 0);
        check("reset valid", {63'd0, valid_a}, 0);
        check("reset freq w4", {60'd0, freq_b}, 0);
        rst = 0;
        en = 1;
        repeat (2) wait_valid();

        // Period 10, then period 100 (saturation on the narrow instance, then recovery).
        gen_hi = 5; gen_lo = 5; gen_run = 1;
        repeat (3) wait_valid();
        gen_hi = 50; gen_lo = 50;
        repeat (2) wait_valid();

        // Enable dropped at gate = 500 for three cycles.
        gen_hi = 5; gen_lo = 5;
        wait_valid();
        repeat (500) @(posedge clk);
        @(negedge clk);
        en = 0;
        repeat (3) @(negedge clk);
        en = 1;
        repeat (2) wait_valid();

        // Single edge whose synchronized rise lands on the terminal cycle.
        gen_run = 0;
        gen_level = 0;
        @(negedge clk);
        en = 0;
        repeat (5) @(negedge clk);
        en = 1;
        @(posedge clk);
        repeat (997) @(posedge clk);
        gen_level = 1;
        repeat (5) @(negedge clk);
        gen_level = 0;
        repeat (2) wait_valid();

        // Asynchronous reset at gate = 300 after a freq = 100 window.
        gen_hi = 5; gen_lo = 5; gen_run = 1;
        repeat (2) wait_valid();
        repeat (300) @(posedge clk);
        #2;
        rst = 1;
        #1;
        check("async rst freq", {32'd0, freq_a}, 0);
        check("async rst overflow", {63'd0, ovf_a}, 0);
        check("async rst valid", {63'd0, valid_a}, 0);
        check("async rst freq w4", {60'd0, freq_b}, 0);
        check("async rst overflow w4", {63'd0, ovf_b}, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (2) wait_valid();

        // Randomized square waves and one random enable glitch.
        for (int i = 0; i < 4; i++) begin
            gen_hi = $urandom_range(2, 30);
            gen_lo = $urandom_range(2, 30);
            wait_valid();
        end
        repeat ($urandom_range(10, 990)) @(posedge clk);
        @(negedge clk);
        en = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        en = 1;
        repeat (2) wait_valid();

        repeat (3) @(negedge clk);
        check("pending windows w32", q_a.size(), 0);
        check("pending windows w4", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
